// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding and default geometry/timing for the SRAM port controller
package sram_ctrl_pkg;
  localparam int ADDR_W_DEF = 19;
  localparam int RD_CYCLES_DEF = 2;
  localparam int WE_CYCLES_DEF = 2;
  typedef enum logic [2:0] {
    IDLE, RD, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, PG_RD, PG_DONE
  } sram_state_t;
endpackage

// File: rtl/sram_port_ctrl_if.sv
// sram_port_ctrl_if: SCARF register-side byte request/ack bus
interface sram_port_ctrl_if import sram_ctrl_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic req;
  logic rnw;
  logic [ADDR_W-1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic ack;
  logic busy;
  modport master(output req, rnw, addr, wdata, input rdata, ack, busy);
  modport slave(input req, rnw, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_cycle_timer.sv
// sram_cycle_timer: 4-bit load/countdown counter; done while the count sits at zero
module sram_cycle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);
  logic [3:0] cnt;
  // load on state entry, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 4'd1;
  end
  assign done = cnt == '0;
endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: sole owner of the async SRAM pins, arbitrating pattern streaming against SCARF byte access
module sram_port_ctrl import sram_ctrl_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WE_CYCLES = WE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_sync,
  input  logic              pattern_active,
  input  logic [ADDR_W-1:0] sram_addr_pat_gen,
  output logic [7:0]        pg_sram_data,
  output logic              pg_data_valid,
  sram_port_ctrl_if.slave   scarf,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_in
);
  sram_state_t state, state_n;
  logic acc, p_rnw, c_rnw, done, load, enter;
  logic [ADDR_W-1:0] p_addr, c_addr, addr_d;
  logic [7:0] p_wdata, c_wdata, dq_out_d, rdata_d, pg_d;
  logic [3:0] load_val;
  logic ce_d, oe_d, we_d, dq_oe_d, pgv_d, ack_d, busy_d;
  assign acc = scarf.req && !scarf.busy;
  assign c_rnw = acc ? scarf.rnw : p_rnw;
  assign c_addr = acc ? scarf.addr : p_addr;
  assign c_wdata = acc ? scarf.wdata : p_wdata;
  sram_cycle_timer u_timer (.clk(clk), .rst(rst_sync), .load(load), .load_val(load_val), .done(done));
  // state, pending slot and every pin register; outputs are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state <= IDLE;
      {p_rnw, p_addr, p_wdata} <= '0;
      {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} <= 4'b1110;
      {sram_addr, sram_dq_out, pg_sram_data, scarf.rdata} <= '0;
      {pg_data_valid, scarf.ack, scarf.busy} <= '0;
    end else begin
      state <= state_n;
      if (acc) {p_rnw, p_addr, p_wdata} <= {scarf.rnw, scarf.addr, scarf.wdata};
      {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} <= {ce_d, oe_d, we_d, dq_oe_d};
      {sram_addr, sram_dq_out, pg_sram_data, scarf.rdata} <= {addr_d, dq_out_d, pg_d, rdata_d};
      {pg_data_valid, scarf.ack, scarf.busy} <= {pgv_d, ack_d, busy_d};
    end
  end
  // sequencing; pattern access wins arbitration, a same-cycle request is served without an extra idle cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:             state_n = pattern_active ? PG_RD : (acc || scarf.busy) ? (c_rnw ? RD : WR_SETUP) : IDLE;
      RD:               state_n = done ? RD_DONE : RD;
      WR_SETUP:         state_n = WR_PULSE;
      WR_PULSE:         state_n = done ? WR_HOLD : WR_PULSE;
      PG_RD:            state_n = done ? PG_DONE : PG_RD;
      PG_DONE:          state_n = pattern_active ? PG_RD : IDLE;
      default:          state_n = IDLE;
    endcase
  end
  // next pin values; address and write data only move on entry to an access, while we_n is high
  always_comb begin
    enter = state_n != state;
    load = enter && (state_n == RD || state_n == WR_PULSE || state_n == PG_RD);
    load_val = state_n == WR_PULSE ? 4'(WE_CYCLES - 1) : 4'(RD_CYCLES - 1);
    ce_d = state_n == IDLE;
    oe_d = !(state_n == RD || state_n == PG_RD);
    we_d = state_n != WR_PULSE;
    dq_oe_d = state_n inside {WR_SETUP, WR_PULSE, WR_HOLD};
    addr_d = (enter && state_n == PG_RD) ? sram_addr_pat_gen :
             (enter && (state_n == RD || state_n == WR_SETUP)) ? c_addr : sram_addr;
    dq_out_d = state_n == WR_SETUP ? c_wdata : sram_dq_out;
    rdata_d = state_n == RD_DONE ? sram_dq_in : scarf.rdata;
    pg_d = state_n == PG_DONE ? sram_dq_in : pg_sram_data;
    pgv_d = state_n == PG_DONE;
    ack_d = state_n == RD_DONE || state_n == WR_HOLD;
    busy_d = acc ? 1'b1 : ack_d ? 1'b0 : scarf.busy;
  end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: scoreboard bench for sram_port_ctrl against a behavioural async SRAM
module tb_sram_port_ctrl;
  typedef struct {
    int         cyc;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_sync, pattern_active;
  logic [18:0] pat_addr, sram_addr;
  logic [7:0] pg_sram_data, sram_dq_out, sram_dq_in;
  logic pg_data_valid, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
  logic [7:0] mem [0:(1<<19)-1];
  logic [7:0] sh [0:7];
  exp_t ack_q[$];
  exp_t pg_q[$];
  exp_t ea, ep;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic prev_rst = 1'b1;
  logic prev_we = 1'b1;
  logic [18:0] prev_addr = '0;

  sram_port_ctrl_if #(.ADDR_W(19)) scarf ();

  sram_port_ctrl #(.ADDR_W(19), .RD_CYCLES(2), .WE_CYCLES(2)) dut (
    .clk(clk), .rst_sync(rst_sync), .pattern_active(pattern_active),
    .sram_addr_pat_gen(pat_addr), .pg_sram_data(pg_sram_data), .pg_data_valid(pg_data_valid),
    .scarf(scarf), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hEE;

  initial begin
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    mem[19'h10] = 8'h5C;
    forever begin
      @(posedge clk);
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rnw, input logic [18:0] addr, input logic [7:0] wd);
    scarf.req = 1'b1;
    scarf.rnw = rnw;
    scarf.addr = addr;
    scarf.wdata = wd;
    tick;
    scarf.req = 1'b0;
  endtask

  task automatic issue(input logic rnw, input logic [18:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input int lat);
    ack_q.push_back('{cyc: cyc + lat, rd: rnw, data: exp_rd});
    drive(rnw, addr, wd);
  endtask

  task automatic push_pg(input int c, input logic [7:0] d);
    pg_q.push_back('{cyc: c, rd: 1'b1, data: d});
  endtask

  // SCARF completion monitor
  always @(negedge clk) begin
    if (!rst_sync && scarf.ack) begin
      if (ack_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else begin
        ea = ack_q.pop_front();
        check("ack_cycle", cyc, ea.cyc);
        if (ea.rd) check("scarf_rdata", {24'd0, scarf.rdata}, {24'd0, ea.data});
      end
    end
  end

  // pattern stream monitor
  always @(negedge clk) begin
    if (!rst_sync && pg_data_valid) begin
      if (pg_q.size() == 0) check("unexpected_pg_valid", 32'd1, 32'd0);
      else begin
        ep = pg_q.pop_front();
        check("pg_cycle", cyc, ep.cyc);
        check("pg_sram_data", {24'd0, pg_sram_data}, {24'd0, ep.data});
      end
    end
  end

  // bus-contention and address-stability invariants
  always @(negedge clk) begin
    if (!rst_sync && !prev_rst) begin
      check("oe_with_dq_oe", {31'd0, !sram_oe_n && sram_dq_oe}, 32'd0);
      check("we_without_dq_oe", {31'd0, !sram_we_n && !sram_dq_oe}, 32'd0);
      check("addr_change_we_low", {31'd0, !prev_we && !sram_we_n && sram_addr != prev_addr}, 32'd0);
    end
    prev_rst = rst_sync;
    prev_we = sram_we_n;
    prev_addr = sram_addr;
  end

  initial begin
    int q;
    int idx;
    rst_sync = 1'b1;
    pattern_active = 1'b0;
    pat_addr = '0;
    scarf.req = 1'b0;
    scarf.rnw = 1'b0;
    scarf.addr = '0;
    scarf.wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_sync = 1'b0;
    check("rst_ctrl_pins", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'he);
    check("rst_addr", {13'd0, sram_addr}, 32'd0);
    check("rst_data", {8'd0, sram_dq_out, pg_sram_data, scarf.rdata}, 32'd0);
    check("rst_flags", {29'd0, pg_data_valid, scarf.ack, scarf.busy}, 32'd0);
    tick;
    issue(1'b0, 19'h12345, 8'hA5, 8'h00, 4);
    repeat (4) tick;
    issue(1'b1, 19'h12345, 8'h00, 8'hA5, 3);
    repeat (4) tick;
    pattern_active = 1'b1;
    pat_addr = 19'd0;
    push_pg(cyc + 3, 8'h11);
    push_pg(cyc + 6, 8'h22);
    push_pg(cyc + 9, 8'h33);
    repeat (3) tick;
    pat_addr = 19'd1;
    repeat (3) tick;
    pat_addr = 19'd2;
    tick;
    pattern_active = 1'b0;
    repeat (5) tick;
    pat_addr = 19'd0;
    pattern_active = 1'b1;
    q = cyc;
    push_pg(q + 3, 8'h11);
    push_pg(q + 6, 8'h11);
    tick;
    issue(1'b1, 19'h00010, 8'h00, 8'h5C, 9);
    check("busy_during_pattern", {31'd0, scarf.busy}, 32'd1);
    tick;
    tick;
    pattern_active = 1'b0;
    check("busy_still_pending", {31'd0, scarf.busy}, 32'd1);
    repeat (8) tick;
    issue(1'b1, 19'h12345, 8'h00, 8'hA5, 3);
    scarf.req = 1'b1;
    scarf.rnw = 1'b0;
    scarf.addr = 19'h0;
    scarf.wdata = 8'hFF;
    tick;
    scarf.rnw = 1'b1;
    scarf.addr = 19'h10;
    tick;
    scarf.req = 1'b0;
    repeat (3) tick;
    issue(1'b1, 19'h0, 8'h00, 8'h11, 3);
    repeat (4) tick;
    for (int i = 0; i < 8; i++) begin
      sh[i] = 8'($urandom);
      issue(1'b0, 19'h100 + 19'(i), sh[i], 8'h00, 4);
      repeat (4 + $urandom_range(0, 2)) tick;
    end
    for (int i = 0; i < 30; i++) begin
      idx = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        sh[idx] = 8'($urandom);
        issue(1'b0, 19'h100 + 19'(idx), sh[idx], 8'h00, 4);
        repeat (4 + $urandom_range(0, 2)) tick;
      end else begin
        issue(1'b1, 19'h100 + 19'(idx), 8'h00, sh[idx], 3);
        repeat (3 + $urandom_range(0, 2)) tick;
      end
    end
    tick;
    drive(1'b0, 19'h20, 8'h77);
    tick;
    check("we_pulse_low", {31'd0, sram_we_n}, 32'd0);
    rst_sync = 1'b1;
    tick;
    rst_sync = 1'b0;
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_busy", {31'd0, scarf.busy}, 32'd0);
    check("abort_idle_ce_n", {30'd0, sram_ce_n, sram_oe_n}, 32'd3);
    repeat (2) tick;
    issue(1'b1, 19'h12345, 8'h00, 8'hA5, 3);
    repeat (6) tick;
    check("ack_queue_drained", ack_q.size(), 32'd0);
    check("pg_queue_drained", pg_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
